// File: rtl/node_stream_tx.sv
// -----------------------------------------------------------------------------
// node_stream_tx
//
// Streams one core's node positions to the display/host path.
//
// A frame_start pulse in IDLE captures the packed X/Y coordinate buses into
// snapshot registers. The block then sends one node per beat over a
// valid/ready interface. The physics core can keep updating its outputs while
// a slow consumer drains the frame. Requests that arrive while a frame is
// still being sent are dropped. Each dropped request is counted in a
// saturating counter.
//
// Ports
//   clk            clock
//   reset          synchronous, active-low reset
//   nodes_x        packed X coordinates, node i at [(i+1)*COORD_W-1 : i*COORD_W]
//   nodes_y        packed Y coordinates, same layout as nodes_x
//   frame_start    single-cycle request to snapshot and send one frame
//   out_valid      beat valid
//   out_ready      consumer ready; a beat transfers when out_valid && out_ready
//   out_x, out_y   coordinates of the node on the current beat
//   out_index      node index of the current beat
//   out_last       marks the beat of node NODE_COUNT-1
//   out_core_id    constant CORE_ID tag
//   busy           high while a frame is being sent
//   frame_done     one-cycle pulse after the final handshake
//   overrun_count  saturating count of dropped frame_start pulses
//
// States
//   state | meaning
//   IDLE  | no frame in flight; frame_start snapshots the inputs and starts a frame
//   SEND  | presenting snapshot node out_index; advances on each handshake
// -----------------------------------------------------------------------------
module node_stream_tx #(
   parameter int NODE_COUNT = 5,
   parameter int COORD_W    = 10,
   parameter int CORE_ID    = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NODE_COUNT*COORD_W-1:0] nodes_x,
   input  logic [NODE_COUNT*COORD_W-1:0] nodes_y,
   input  logic                          frame_start,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [COORD_W-1:0]            out_x,
   output logic [COORD_W-1:0]            out_y,
   output logic [7:0]                    out_index,
   output logic                          out_last,
   output logic [7:0]                    out_core_id,
   output logic                          busy,
   output logic                          frame_done,
   output logic [7:0]                    overrun_count
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(NODE_COUNT - 1);

   state_t                          state_q, state_d;
   logic [7:0]                      idx_q, idx_d;
   logic                            done_q, done_d;
   logic [7:0]                      ovr_q, ovr_d;
   logic                            capture;
   logic [NODE_COUNT*COORD_W-1:0]   snap_x_q;
   logic [NODE_COUNT*COORD_W-1:0]   snap_y_q;
   logic [COORD_W-1:0]              sel_x, sel_y;
   logic                            is_last;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= 8'd0;
         done_q  <= 1'b0;
         ovr_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
      end
   end

   // Snapshot contents are only meaningful in SEND, so they carry no reset.
   always_ff @(posedge clk) begin
      if (capture) begin
         snap_x_q <= nodes_x;
         snap_y_q <= nodes_y;
      end
   end

   assign is_last = (idx_q == LAST_IDX);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      ovr_d   = ovr_q;
      capture = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (frame_start) begin
               capture = 1'b1;
               state_d = SEND;
               idx_d   = 8'd0;
            end
         end
         SEND: begin
            // Requests during SEND are never queued, including the cycle of
            // the final handshake.
            if (frame_start && (ovr_q != 8'hFF)) begin
               ovr_d = ovr_q + 8'd1;
            end
            if (out_ready) begin
               if (is_last) begin
                  state_d = IDLE;
                  idx_d   = 8'd0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = 8'd0;
         end
      endcase
   end

   // The snapshot field is picked by out_index. A compare-per-node mux keeps the
   // select in range for any legal NODE_COUNT.
   always_comb begin
      sel_x = '0;
      sel_y = '0;
      for (int i = 0; i < NODE_COUNT; i++) begin
         if (idx_q == 8'(i)) begin
            sel_x = snap_x_q[i*COORD_W +: COORD_W];
            sel_y = snap_y_q[i*COORD_W +: COORD_W];
         end
      end
   end

   // In IDLE the data outputs are forced to zero. The snapshot may hold stale
   // or uninitialised data at that time.
   assign out_valid     = (state_q == SEND);
   assign busy          = (state_q == SEND);
   assign out_x         = (state_q == SEND) ? sel_x : '0;
   assign out_y         = (state_q == SEND) ? sel_y : '0;
   assign out_index     = idx_q;
   assign out_last      = (state_q == SEND) && is_last;
   assign out_core_id   = 8'(CORE_ID);
   assign frame_done    = done_q;
   assign overrun_count = ovr_q;

endmodule

// File: tb/tb_node_stream_tx.sv
module tb_node_stream_tx;

   localparam int N = 5;
   localparam int W = 10;

   logic           clk = 1'b0;
   logic           reset;
   logic [N*W-1:0] nodes_x, nodes_y;
   logic           frame_start;
   logic           out_valid, out_ready;
   logic [W-1:0]   out_x, out_y;
   logic [7:0]     out_index, out_core_id, overrun_count;
   logic           out_last, busy, frame_done;

   int checks = 0;
   int errors = 0;
   int hs     = 0;
   int hs0;

   logic [W-1:0] bx [N];
   logic [W-1:0] by [N];

   node_stream_tx #(.NODE_COUNT(N), .COORD_W(W), .CORE_ID(3)) dut (
      .clk(clk), .reset(reset), .nodes_x(nodes_x), .nodes_y(nodes_y),
      .frame_start(frame_start), .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_index(out_index), .out_last(out_last),
      .out_core_id(out_core_id), .busy(busy), .frame_done(frame_done),
      .overrun_count(overrun_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset && out_valid && out_ready) hs <= hs + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_nodes();
      for (int i = 0; i < N; i++) begin
         nodes_x[i*W +: W] = bx[i];
         nodes_y[i*W +: W] = by[i];
      end
   endtask

   task automatic chk_beat(input string tag, input int i, input int ex, input int ey);
      chk({tag, " valid"}, 32'(out_valid), 32'd1);
      chk({tag, " busy"},  32'(busy),      32'd1);
      chk({tag, " x"},     32'(out_x),     32'(ex));
      chk({tag, " y"},     32'(out_y),     32'(ey));
      chk({tag, " index"}, 32'(out_index), 32'(i));
      chk({tag, " last"},  32'(out_last),  32'(i == N - 1));
      chk({tag, " done"},  32'(frame_done), 32'd0);
   endtask

   task automatic chk_idle(input string tag, input int edone);
      chk({tag, " valid"}, 32'(out_valid),  32'd0);
      chk({tag, " busy"},  32'(busy),       32'd0);
      chk({tag, " done"},  32'(frame_done), 32'(edone));
      chk({tag, " index"}, 32'(out_index),  32'd0);
   endtask

   initial begin
      reset = 1'b0; frame_start = 1'b0; out_ready = 1'b1;
      nodes_x = '0; nodes_y = '0;

      // 1: reset
      repeat (3) step();
      reset = 1'b1;
      step();
      chk_idle("rst", 0);
      chk("rst ovr",  32'(overrun_count), 32'd0);
      chk("rst x",    32'(out_x),         32'd0);
      chk("rst y",    32'(out_y),         32'd0);
      chk("rst last", 32'(out_last),      32'd0);
      chk("rst core", 32'(out_core_id),   32'd3);

      // 2: basic frame
      bx = '{10'd10, 10'd20, 10'd30, 10'd40, 10'd50};
      by = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd5};
      load_nodes();
      hs0 = hs;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      for (int i = 0; i < N; i++) begin
         chk_beat("basic", i, 10 * (i + 1), i + 1);
         step();
      end
      chk_idle("basic end", 1);
      chk("basic hs", 32'(hs - hs0), 32'd5);
      step();
      chk_idle("basic after", 0);

      // 3: back-pressure and snapshot isolation
      hs0 = hs;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk_beat("bp", 0, 10, 1);
      step();
      chk_beat("bp", 1, 20, 2);
      nodes_x = {N{10'd1023}};
      step();
      chk_beat("bp", 2, 30, 3);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk_beat("bp hold", 2, 30, 3);
      end
      out_ready = 1'b1;
      step();
      chk_beat("bp", 3, 40, 4);
      step();
      chk_beat("bp", 4, 50, 5);
      step();
      chk_idle("bp end", 1);
      chk("bp hs", 32'(hs - hs0), 32'd5);
      load_nodes();
      step();

      // 4: overrun
      hs0 = hs;
      frame_start = 1'b1;
      step();
      chk_beat("ovr", 0, 10, 1);
      step();
      frame_start = 1'b0;
      chk_beat("ovr", 1, 20, 2);
      chk("ovr cnt1", 32'(overrun_count), 32'd1);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk_beat("ovr", 2, 30, 3);
      chk("ovr cnt2", 32'(overrun_count), 32'd2);
      step();
      chk_beat("ovr", 3, 40, 4);
      step();
      chk_beat("ovr", 4, 50, 5);
      step();
      chk_idle("ovr end", 1);
      chk("ovr hs", 32'(hs - hs0), 32'd5);
      chk("ovr cnt end", 32'(overrun_count), 32'd2);
      // stall a frame and drop 298 more pulses (300 in total)
      out_ready = 1'b0;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      for (int k = 0; k < 298; k++) begin
         frame_start = 1'b1;
         step();
         frame_start = 1'b0;
         step();
      end
      chk("ovr sat", 32'(overrun_count), 32'd255);
      chk_beat("ovr stall", 0, 10, 1);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("ovr sat hold", 32'(overrun_count), 32'd255);
      out_ready = 1'b1;
      repeat (N) step();
      chk_idle("ovr sat end", 1);
      step();

      // 5: mid-frame reset, then restart with fresh data
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      step();
      chk_beat("mid", 1, 20, 2);
      step();
      chk_beat("mid", 2, 30, 3);
      step();
      reset = 1'b0;
      step();
      chk_idle("mid rst", 0);
      chk("mid rst ovr", 32'(overrun_count), 32'd0);
      reset = 1'b1;
      step();
      chk_idle("mid rel", 0);
      bx = '{10'd100, 10'd200, 10'd300, 10'd400, 10'd500};
      by = '{10'd7, 10'd8, 10'd9, 10'd10, 10'd11};
      load_nodes();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      for (int i = 0; i < N; i++) begin
         chk_beat("restart", i, 100 * (i + 1), 7 + i);
         step();
      end
      chk_idle("restart end", 1);
      step();

      // 6a: frame_start on the final handshake is dropped
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      repeat (N - 1) step();
      chk_beat("b6a", 4, 500, 11);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk_idle("b6a done", 1);
      chk("b6a ovr", 32'(overrun_count), 32'd1);
      step();
      chk_idle("b6a no frame", 0);

      // 6b: frame_start in the frame_done cycle is accepted
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      repeat (N - 1) step();
      chk_beat("b6b", 4, 500, 11);
      step();
      chk_idle("b6b done", 1);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk_beat("b6b new", 0, 100, 7);
      chk("b6b ovr", 32'(overrun_count), 32'd1);
      repeat (N) step();
      chk_idle("b6b end", 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/node_stream_tx.md
Name: node_stream_tx

Overview:
Reader-side counterpart of the simulation core's packed node position outputs. On a frame strobe it snapshots the packed per-node X/Y coordinate buses of one core. It then streams the coordinates one node per beat over a valid/ready interface toward the display/host path. It decouples the free-running physics update from a back-pressured consumer, and counts frame requests it had to drop.

Parameters:
NODE_COUNT, 5, nodes per core; legal range 2..256.
COORD_W, 10, bits per packed coordinate field.
CORE_ID, 1, constant tag driven on out_core_id; 0..255.

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-low reset.
nodes_x  input  NODE_COUNT*COORD_W  packed X; node i occupies bits [(i+1)*COORD_W-1 : i*COORD_W].
nodes_y  input  NODE_COUNT*COORD_W  packed Y; same layout as nodes_x.
frame_start  input  1  single-cycle request to snapshot and send one frame.
out_valid  output  1  beat valid.
out_ready  input  1  consumer accepts the beat when out_valid && out_ready.
out_x  output  COORD_W  X of the current node.
out_y  output  COORD_W  Y of the current node.
out_index  output  8  node index of the current beat, 0..NODE_COUNT-1.
out_last  output  1  high on the beat with out_index == NODE_COUNT-1.
out_core_id  output  8  constant CORE_ID.
busy  output  1  high while in SEND.
frame_done  output  1  one-cycle pulse after the final handshake.
overrun_count  output  8  saturating count of dropped frame_start pulses.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE. out_valid, out_last, busy, frame_done = 0. out_x, out_y, out_index = 0. overrun_count = 0. Snapshot registers are don't-care. Reset mid-frame aborts the frame: no further beats and no frame_done.
- States: IDLE, SEND.
- IDLE with frame_start=1:
  - Capture all of nodes_x and nodes_y into snapshot registers on that edge.
  - Next state is SEND, with out_index=0.
  - First beat is valid the cycle after frame_start (latency 1).
- IDLE with frame_start=0: remain in IDLE, out_valid=0.
- SEND:
  - out_valid=1.
  - out_x and out_y = snapshot fields for out_index.
  - out_last = (out_index == NODE_COUNT-1).
- Handshake when out_valid && out_ready:
  - Non-last beat: out_index increments next cycle.
  - Last beat: next state is IDLE, out_valid=0, out_index returns to 0, and frame_done=1 for exactly that next cycle.
- Back-pressure: while out_valid && !out_ready, out_x, out_y, out_index and out_last hold stable. No beat is skipped or repeated.
- Snapshot isolation: changes on nodes_x/nodes_y during SEND do not affect the beats of the frame in progress.
- Dropped requests:
  - frame_start while in SEND, including the final-handshake cycle, is dropped. The request is not queued.
  - Each drop increments overrun_count, saturating at 255.
- frame_start during the frame_done cycle is accepted, because the state is already IDLE.
- Throughput: with out_ready held high, a frame takes NODE_COUNT consecutive beats. A new frame can begin 1 cycle after the last beat, i.e. the minimum start-to-start spacing is NODE_COUNT+1 cycles.
- Widths: coordinates are passed through unmodified. There is no arithmetic on data. The out_index counter is 8 bits wide.

Test Plan:
(Run with NODE_COUNT=5, COORD_W=10, CORE_ID=3.)
1. Reset check: hold reset=0 for 3 cycles, then release with frame_start=0 -> out_valid=0, busy=0, frame_done=0, overrun_count=0, out_x=out_y=out_index=0, out_core_id=3.
2. Basic frame:
   - Stimulus: nodes_x fields 10,20,30,40,50 and nodes_y fields 1,2,3,4,5 (node0 first), frame_start pulse at cycle T, out_ready=1.
   - Response: beats (10,1,0) through (50,5,4) at cycles T+1..T+5, out_last only at T+5, busy high T+1..T+5, frame_done high only at T+6.
3. Back-pressure and isolation:
   - Stimulus: same frame, out_ready=0 for 3 cycles while (30,3,2) is presented; at T+2, change nodes_x to all 1023.
   - Response: (30,3,2) is held stable for 4 cycles. All beats carry the original snapshot values. Exactly 5 handshakes occur.
4. Overrun:
   - Stimulus: two frame_start pulses during SEND.
   - Response: overrun_count=2 and the frame completes with 5 beats.
   - Further stimulus: 300 drop pulses in total -> overrun_count=255.
5. Mid-frame reset and restart:
   - Stimulus: reset=0 at the edge after the handshake of beat index 2.
   - Response: the next cycle has out_valid=0, busy=0, overrun_count=0, and no frame_done.
   - Further stimulus: after release, a frame_start pulse -> the frame restarts at index 0 with freshly captured data.
6. Boundary timing:
   - frame_start on the same cycle as the final handshake -> dropped, overrun_count increments by 1, no new frame.
   - frame_start in the frame_done cycle -> accepted, next beat is index 0 one cycle later.
